// File: rtl/id_issue_ctrl_if.sv
// Fetch, EX, writeback and status signals of the decode issue controller.
// master drives fetch/EX-ready/writeback/flush; slave is the controller itself.
interface id_issue_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             if_valid;
  logic [31:0]      if_instr;
  logic             id_ready;
  logic             ex_valid;
  logic             ex_ready;
  logic [31:0]      ex_instr;
  logic             ex_illegal;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             flush;
  logic [3:0]       inflight;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output if_valid, if_instr, ex_ready, wb_valid, wb_rd, flush,
    input  id_ready, ex_valid, ex_instr, ex_illegal, inflight, stall_cycles
  );

  modport slave (
    input  if_valid, if_instr, ex_ready, wb_valid, wb_rd, flush,
    output id_ready, ex_valid, ex_instr, ex_illegal, inflight, stall_cycles
  );
endinterface

// File: rtl/id_issue_ctrl.sv
// Single-slot RV32I issue controller with a write scoreboard; 1-cycle accept-to-issue latency.
// Holds the slot (id_ready low) while a RAW/WAW/capacity hazard blocks issue or EX is not ready.
module id_issue_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  id_issue_ctrl_if.slave bus
);

  typedef enum logic [0:0] {S_EMPTY, S_FULL} slot_state_e;

  // {uses_rs1, uses_rs2, writes_rd} before the rd==x0 override
  function automatic logic [2:0] op_class(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111: op_class = 3'b001;
      7'b1100111, 7'b0000011, 7'b0010011: op_class = 3'b101;
      7'b1100011, 7'b0100011:             op_class = 3'b110;
      7'b0110011:                         op_class = 3'b111;
      default:                            op_class = 3'b000;
    endcase
  endfunction

  function automatic logic op_illegal(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
      7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011: op_illegal = 1'b0;
      default:                                                    op_illegal = 1'b1;
    endcase
  endfunction

  slot_state_e      r_state;
  logic [31:0]      r_instr;
  logic             r_illegal;
  logic [31:0]      r_sb;
  logic [3:0]       r_inflight;
  logic [CNT_W-1:0] r_stall_cnt;

  logic        w_slot_vld;
  logic [2:0]  w_cls;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_writes_rd;
  logic        w_clr;
  logic [31:0] w_clr_mask;
  logic [31:0] w_sb_eff;
  logic [3:0]  w_inflight_eff;
  logic        w_hazard;
  logic        w_ex_valid;
  logic        w_issue;
  logic        w_id_ready;
  logic        w_accept;
  logic        w_set;
  logic [31:0] w_set_mask;

  assign w_slot_vld  = (r_state == S_FULL);
  assign w_cls       = op_class(r_instr[6:0]);
  assign w_rd        = r_instr[11:7];
  assign w_rs1       = r_instr[19:15];
  assign w_rs2       = r_instr[24:20];
  assign w_writes_rd = w_cls[0] && (w_rd != 5'd0);

  // A retiring write is visible this cycle so a dependent instruction issues alongside it
  assign w_clr          = bus.wb_valid && (bus.wb_rd != 5'd0) && r_sb[bus.wb_rd];
  assign w_clr_mask     = w_clr ? (32'd1 << bus.wb_rd) : 32'd0;
  assign w_sb_eff       = r_sb & ~w_clr_mask;
  assign w_inflight_eff = r_inflight - {3'b000, w_clr};

  assign w_hazard = (w_cls[2] && w_sb_eff[w_rs1]) ||
                    (w_cls[1] && w_sb_eff[w_rs2]) ||
                    (w_writes_rd && w_sb_eff[w_rd]) ||
                    (w_writes_rd && (w_inflight_eff == 4'(MAX_INFLIGHT)));

  assign w_ex_valid = w_slot_vld && !w_hazard && !bus.flush;
  assign w_issue    = w_ex_valid && bus.ex_ready;
  assign w_id_ready = !bus.flush && (!w_slot_vld || w_issue);
  assign w_accept   = bus.if_valid && w_id_ready;
  assign w_set      = w_issue && w_writes_rd;
  assign w_set_mask = w_set ? (32'd1 << w_rd) : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_EMPTY;
      r_instr   <= 32'd0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state   <= S_FULL;
            r_instr   <= bus.if_instr;
            r_illegal <= op_illegal(bus.if_instr[6:0]);
          end
        end
        S_FULL: begin
          if (w_accept) begin
            r_instr   <= bus.if_instr;
            r_illegal <= op_illegal(bus.if_instr[6:0]);
          end else if (w_issue || bus.flush) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  // Set is OR-ed after the clear so a same-register set/clear leaves the bit pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb        <= 32'd0;
      r_inflight  <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      r_sb       <= w_sb_eff | w_set_mask;
      r_inflight <= r_inflight + {3'b000, w_set} - {3'b000, w_clr};
      if (w_slot_vld && !bus.flush && !w_issue && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.id_ready     = w_id_ready;
  assign bus.ex_valid     = w_ex_valid;
  assign bus.ex_instr     = r_instr;
  assign bus.ex_illegal   = r_illegal;
  assign bus.inflight     = r_inflight;
  assign bus.stall_cycles = r_stall_cnt;

endmodule
